ysyx_2022040010_shift_arb: RTL and testbench

// - Shares the single 64-bit shift datapath between two requesters (req0: EXU ALU path, req1: multi-cycle/CSR

---
 rtl/ysyx_2022040010_shift_arb_pkg.sv | 27 ++
 rtl/ysyx_2022040010_shift.sv | 34 +++
 rtl/ysyx_2022040010_shift_arb.sv | 135 +++++++++++++
 tb/tb_ysyx_2022040010_shift_arb.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_2022040010_shift_arb_pkg.sv
// Shared definitions for the shift arbiter: op encodings, FSM states and the
// registered operand bundle handed from the arbiter to the shift unit.
package ysyx_2022040010_shift_arb_pkg;

  localparam logic [2:0] SHIFT_OP_SLL = 3'b100;
  localparam logic [2:0] SHIFT_OP_SRL = 3'b010;
  localparam logic [2:0] SHIFT_OP_SRA = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [63:0] operand;
    logic [5:0]  amt;
    logic [2:0]  op;
    logic        alu_32;
  } shift_req_t;

  // *W ops only honour the low 5 amount bits.
  function automatic logic [5:0] mask_amt(input logic [63:0] amount, input logic alu_32);
    return alu_32 ? {1'b0, amount[4:0]} : amount[5:0];
  endfunction

endpackage

// File: rtl/ysyx_2022040010_shift.sv
// Combinational RV64 shift unit: SLL/SRL/SRA plus *W variants with sign-extension.
module ysyx_2022040010_shift
  import ysyx_2022040010_shift_arb_pkg::*;
(
  input  logic [63:0] operand,
  input  logic [5:0]  amt,
  input  logic [2:0]  op,
  input  logic        alu_32,
  output logic [63:0] result
);

  logic [31:0] w_src;
  logic [63:0] sll64, srl64, sra64;
  logic [31:0] sllw, srlw, sraw;

  assign w_src = operand[31:0];
  assign sll64 = operand << amt;
  assign srl64 = operand >> amt;
  assign sra64 = $signed(operand) >>> amt;
  assign sllw  = w_src << amt[4:0];
  assign srlw  = w_src >> amt[4:0];
  assign sraw  = $signed(w_src) >>> amt[4:0];

  always_comb begin
    result = '0;
    if ((op & SHIFT_OP_SLL) != 3'b000)
      result = alu_32 ? {{32{sllw[31]}}, sllw} : sll64;
    else if ((op & SHIFT_OP_SRL) != 3'b000)
      result = alu_32 ? {{32{srlw[31]}}, srlw} : srl64;
    else if ((op & SHIFT_OP_SRA) != 3'b000)
      result = alu_32 ? {{32{sraw[31]}}, sraw} : sra64;
  end

endmodule

// File: rtl/ysyx_2022040010_shift_arb.sv
// Two-requester arbiter in front of the shared 64-bit shifter: grant, register
// operands, one EXEC cycle, then hold the result until the consumer takes it.
module ysyx_2022040010_shift_arb
  import ysyx_2022040010_shift_arb_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [63:0]      req0_operand,
  input  logic [63:0]      req0_amount,
  input  logic [2:0]       req0_op,
  input  logic             req0_alu_32,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [63:0]      req1_operand,
  input  logic [63:0]      req1_amount,
  input  logic [2:0]       req1_op,
  input  logic             req1_alu_32,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [63:0]      resp_result,
  output logic             resp_id,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam int NUM_REQ = 2;

  state_t state, state_nxt;
  logic                              last_grant;
  logic                              gnt_id;
  logic                              accept_win;
  logic                              hs;
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0][63:0]          req_operand;
  logic [NUM_REQ-1:0][63:0]          req_amount;
  logic [NUM_REQ-1:0][2:0]           req_op;
  logic [NUM_REQ-1:0]                req_alu_32;
  logic [NUM_REQ-1:0][TAG_W-1:0]     req_tag;
  shift_req_t [NUM_REQ-1:0]          req_m;
  shift_req_t                        op_q;
  logic                              id_q;
  logic [TAG_W-1:0]                  tag_q;
  logic [63:0]                       shift_result;
  logic                              amt_hi_unused;

  assign req_valid   = {req1_valid, req0_valid};
  assign req_operand = {req1_operand, req0_operand};
  assign req_amount  = {req1_amount, req0_amount};
  assign req_op      = {req1_op, req0_op};
  assign req_alu_32  = {req1_alu_32, req0_alu_32};
  assign req_tag     = {req1_tag, req0_tag};
  assign amt_hi_unused = ^{req1_amount[63:6], req0_amount[63:6]};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign req_m[g] = '{operand: req_operand[g],
                        amt:     mask_amt(req_amount[g], req_alu_32[g]),
                        op:      req_op[g],
                        alu_32:  req_alu_32[g]};
  end

  always_comb begin
    gnt_id = 1'b0;
    case (req_valid)
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = RR_EN ? ~last_grant : 1'b0;
      default: gnt_id = 1'b0;
    endcase
  end

  // Ready is gated by rst_n so outputs read 0 the moment reset asserts.
  assign accept_win = rst_n && !flush &&
                      (state == ST_IDLE || (state == ST_RESP && resp_ready));
  assign req_ready  = accept_win ? (req_valid & (gnt_id ? 2'b10 : 2'b01)) : 2'b00;
  assign hs         = |req_ready;
  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (hs) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = hs ? ST_EXEC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      op_q        <= '0;
      id_q        <= 1'b0;
      tag_q       <= '0;
      resp_result <= '0;
      resp_id     <= 1'b0;
      resp_tag    <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        last_grant <= gnt_id;
        op_q       <= req_m[gnt_id];
        id_q       <= gnt_id;
        tag_q      <= req_tag[gnt_id];
      end
      if (state == ST_EXEC && !flush) begin
        resp_result <= shift_result;
        resp_id     <= id_q;
        resp_tag    <= tag_q;
      end
    end
  end

  assign resp_valid = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);

  ysyx_2022040010_shift u_shift (
    .operand (op_q.operand),
    .amt     (op_q.amt),
    .op      (op_q.op),
    .alu_32  (op_q.alu_32),
    .result  (shift_result)
  );

endmodule

// File: tb/tb_ysyx_2022040010_shift_arb.sv
// Scoreboard bench for the shift arbiter; a second fixed-priority instance
// shares the inputs and must always grant req0.
module tb_ysyx_2022040010_shift_arb;

  localparam int TAG_W = 4;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic req0_valid = 0, req1_valid = 0, resp_ready = 0;
  logic [63:0] req0_operand = '0, req0_amount = '0, req1_operand = '0, req1_amount = '0;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic req0_alu_32 = 0, req1_alu_32 = 0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic req0_ready, req1_ready, resp_valid, resp_id, busy;
  logic [63:0] resp_result;
  logic [TAG_W-1:0] resp_tag;
  logic fp_req0_ready, fp_req1_ready, fp_resp_valid, fp_resp_id, fp_busy;
  logic [63:0] fp_resp_result;
  logic [TAG_W-1:0] fp_resp_tag;

  always #5 clk = ~clk;

  ysyx_2022040010_shift_arb #(.TAG_W(TAG_W), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_operand(req0_operand),
    .req0_amount(req0_amount), .req0_op(req0_op), .req0_alu_32(req0_alu_32), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_operand(req1_operand),
    .req1_amount(req1_amount), .req1_op(req1_op), .req1_alu_32(req1_alu_32), .req1_tag(req1_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_id(resp_id), .resp_tag(resp_tag), .busy(busy));

  ysyx_2022040010_shift_arb #(.TAG_W(TAG_W), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_operand(req0_operand),
    .req0_amount(req0_amount), .req0_op(req0_op), .req0_alu_32(req0_alu_32), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_operand(req1_operand),
    .req1_amount(req1_amount), .req1_op(req1_op), .req1_alu_32(req1_alu_32), .req1_tag(req1_tag),
    .resp_valid(fp_resp_valid), .resp_ready(resp_ready), .resp_result(fp_resp_result),
    .resp_id(fp_resp_id), .resp_tag(fp_resp_tag), .busy(fp_busy));

  typedef struct {
    logic [63:0]      res;
    logic             id;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int grants[$];
  int cyc = 0;
  int n_tests = 0, n_fail = 0;
  bit hs0, hs1, resp_seen;
  int resp_first;
  logic [63:0] last_result;
  logic last_id;

  // Bit-by-bit reference shifter.
  function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    int sh, n;
    logic [63:0] r;
    logic fill;
    r = '0;
    n = w ? 32 : 64;
    sh = w ? int'(b[4:0]) : int'(b[5:0]);
    fill = a[n-1];
    for (int i = 0; i < n; i++) begin
      if (op[2])      r[i] = (i >= sh) ? a[i-sh] : 1'b0;
      else if (op[1]) r[i] = (i + sh < n) ? a[i+sh] : 1'b0;
      else if (op[0]) r[i] = (i + sh < n) ? a[i+sh] : fill;
    end
    if (w) r[63:32] = {32{r[31]}};
    return r;
  endfunction

  task automatic step();
    exp_t e, g;
    #1;
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
    n_tests++;
    if (req0_ready && req1_ready) begin
      n_fail++; $display("FAIL one_ready: got r0=%b r1=%b required at most one", req0_ready, req1_ready);
    end
    if (hs0) begin
      e.res = model(req0_op, req0_alu_32, req0_operand, req0_amount);
      e.id = 1'b0; e.tag = req0_tag; e.cyc = cyc; sb.push_back(e); grants.push_back(0);
    end
    if (hs1) begin
      e.res = model(req1_op, req1_alu_32, req1_operand, req1_amount);
      e.id = 1'b1; e.tag = req1_tag; e.cyc = cyc; sb.push_back(e); grants.push_back(1);
    end
    if (resp_valid) begin
      if (!resp_seen) begin resp_seen = 1; resp_first = cyc; end
      if (resp_ready && !flush) begin
        resp_seen = 0; last_result = resp_result; last_id = resp_id;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL spurious_resp: got result %h with no outstanding op", resp_result);
        end else begin
          g = sb.pop_front();
          if ({resp_result, resp_id, resp_tag} !== {g.res, g.id, g.tag}) begin
            n_fail++;
            $display("FAIL resp_data: got res=%h id=%b tag=%h required res=%h id=%b tag=%h",
                     resp_result, resp_id, resp_tag, g.res, g.id, g.tag);
          end
          n_tests++;
          if (resp_first != g.cyc + 2) begin
            n_fail++; $display("FAIL latency: got %0d cycles required 2", resp_first - g.cyc);
          end
        end
      end
    end
    if (flush) resp_seen = 0;
    @(posedge clk); cyc++; @(negedge clk);
  endtask

  task automatic issue(input logic n, input logic [2:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] tag);
    bit ok = 0;
    if (n) begin
      req1_valid = 1; req1_op = op; req1_alu_32 = w; req1_operand = a; req1_amount = b; req1_tag = tag;
    end else begin
      req0_valid = 1; req0_op = op; req0_alu_32 = w; req0_operand = a; req0_amount = b; req0_tag = tag;
    end
    for (int k = 0; k < 20; k++) begin
      step();
      if (n ? hs1 : hs0) begin ok = 1; break; end
    end
    req0_valid = 0; req1_valid = 0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL issue_timeout: got no handshake required one for req%0d", n); end
  endtask

  task automatic drain();
    resp_ready = 1;
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0 && !resp_valid) break;
      step();
    end
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL drain_timeout: got %0d outstanding required 0", sb.size()); end
  endtask

  task automatic do_reset();
    rst_n = 0; sb.delete(); resp_seen = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; req0_valid = 1; req1_valid = 1; resp_ready = 1;
    @(negedge clk); @(negedge clk); #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b required 00", {req0_ready, req1_ready}); end
    n_tests++;
    if ({resp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_valid_busy: got %b required 00", {resp_valid, busy}); end
    n_tests++;
    if ({resp_result, resp_id, resp_tag} !== '0) begin
      n_fail++; $display("FAIL reset_resp: got res=%h id=%b tag=%h required 0", resp_result, resp_id, resp_tag);
    end
    req0_valid = 0; req1_valid = 0; resp_ready = 0;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_single();
    issue(1'b0, 3'b100, 1'b0, 64'h1, 64'h4, 4'h3);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b required 1", busy); end
    drain();
    n_tests++;
    if (last_result !== 64'h10 || last_id !== 1'b0) begin
      n_fail++; $display("FAIL single_sll: got %h id %b required 10 id 0", last_result, last_id);
    end
  endtask

  task automatic test_req1();
    issue(1'b1, 3'b001, 1'b1, 64'h80000000, 64'h24, 4'h5);
    drain();
    n_tests++;
    if (last_result !== 64'hFFFFFFFFF8000000 || last_id !== 1'b1) begin
      n_fail++; $display("FAIL sraw_mask: got %h id %b required fffffffff8000000 id 1", last_result, last_id);
    end
    issue(1'b1, 3'b010, 1'b0, 64'h8000000000000000, 64'h7F, 4'h6);
    drain();
    n_tests++;
    if (last_result !== 64'h1) begin n_fail++; $display("FAIL srl_mask: got %h required 1", last_result); end
    issue(1'b0, 3'b000, 1'b0, 64'hDEADBEEF, 64'h3, 4'h7);
    drain();
    n_tests++;
    if (last_result !== 64'h0) begin n_fail++; $display("FAIL op_none: got %h required 0", last_result); end
    issue(1'b0, 3'b111, 1'b1, 64'h40000001, 64'hFFFF_FFE1, 4'h8);
    drain();
  endtask

  task automatic rand_req(input logic n);
    if (n) begin
      req1_operand = {$urandom, $urandom}; req1_amount = {$urandom, $urandom};
      req1_op = 3'($urandom); req1_alu_32 = 1'($urandom); req1_tag = req1_tag + 1'b1;
    end else begin
      req0_operand = {$urandom, $urandom}; req0_amount = {$urandom, $urandom};
      req0_op = 3'($urandom); req0_alu_32 = 1'($urandom); req0_tag = req0_tag + 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    grants.delete();
    resp_ready = 1; rand_req(0); rand_req(1);
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 24; k++) begin
      step();
      if (hs0) rand_req(0);
      if (hs1) rand_req(1);
      #1;
      n_tests++;
      if (fp_req1_ready !== 1'b0 || fp_req0_ready !== (req0_ready | req1_ready)) begin
        n_fail++; $display("FAIL fixed_prio_ready: got r0=%b r1=%b required r0=%b r1=0",
                           fp_req0_ready, fp_req1_ready, req0_ready | req1_ready);
      end
      n_tests++;
      if (fp_resp_valid && fp_resp_id !== 1'b0) begin
        n_fail++; $display("FAIL fixed_prio_id: got %b required 0", fp_resp_id);
      end
    end
    req0_valid = 0; req1_valid = 0;
    drain();
    n_tests++;
    if (grants.size() < 10) begin n_fail++; $display("FAIL rr_count: got %0d grants required >=10", grants.size()); end
    foreach (grants[i]) begin
      n_tests++;
      if (grants[i] != (i % 2)) begin n_fail++; $display("FAIL rr_order: grant %0d got req%0d required req%0d", i, grants[i], i % 2); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] snap_res;
    logic snap_id;
    logic [TAG_W-1:0] snap_tag;
    resp_ready = 0;
    issue(1'b0, 3'b100, 1'b0, 64'h123, 64'h8, 4'h9);
    req0_valid = 1; req1_valid = 1; req0_tag = 4'hA; req1_tag = 4'hB;
    req0_op = 3'b010; req1_op = 3'b001; req1_operand = 64'hF0; req1_amount = 64'h2; req1_alu_32 = 0;
    step();
    snap_res = resp_result; snap_id = resp_id; snap_tag = resp_tag;
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++;
      if (resp_valid !== 1'b1 || {resp_result, resp_id, resp_tag} !== {snap_res, snap_id, snap_tag}) begin
        n_fail++; $display("FAIL bp_stable: got v=%b res=%h required v=1 res=%h", resp_valid, resp_result, snap_res);
      end
      n_tests++;
      if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_ready: got %b required 00", {req0_ready, req1_ready}); end
    end
    resp_ready = 1; #1;
    n_tests++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      n_fail++; $display("FAIL bp_accept: got r1r0=%b required 10", {req1_ready, req0_ready});
    end
    step();
    req0_valid = 0; req1_valid = 0;
    drain();
  endtask

  task automatic test_flush();
    resp_ready = 0;
    issue(1'b0, 3'b100, 1'b0, 64'h5, 64'h1, 4'h1);
    flush = 1; step(); flush = 0;
    sb.delete();
    n_tests++;
    if ({busy, resp_valid} !== 2'b00) begin n_fail++; $display("FAIL flush_exec: got busy/valid %b required 00", {busy, resp_valid}); end
    step(); step();
    n_tests++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_exec_resp: got %b required 0", resp_valid); end
    issue(1'b0, 3'b010, 1'b0, 64'h50, 64'h4, 4'h2);
    step();
    resp_ready = 1; flush = 1; req1_valid = 1; req1_tag = 4'hC; #1;
    n_tests++;
    if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL flush_ready: got %b required 00", {req0_ready, req1_ready}); end
    step(); flush = 0; req1_valid = 0;
    n_tests++;
    if (hs1) begin n_fail++; $display("FAIL flush_accept: got handshake required none"); end
    sb.delete();
    n_tests++;
    if ({busy, resp_valid} !== 2'b00) begin n_fail++; $display("FAIL flush_resp: got busy/valid %b required 00", {busy, resp_valid}); end
    step();
    n_tests++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_resp_after: got %b required 0", resp_valid); end
  endtask

  task automatic test_async_reset();
    resp_ready = 0;
    issue(1'b0, 3'b100, 1'b0, 64'h7, 64'h3, 4'h4);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL ar_busy_before: got %b required 1", busy); end
    #2 rst_n = 0; #1;
    n_tests++;
    if ({busy, resp_valid, req0_ready, req1_ready, resp_result, resp_id, resp_tag} !== '0) begin
      n_fail++; $display("FAIL async_reset: got busy=%b v=%b res=%h required all 0", busy, resp_valid, resp_result);
    end
    sb.delete(); resp_seen = 0;
    @(negedge clk); rst_n = 1;
    req0_valid = 1; req1_valid = 1; req0_op = 3'b100; req1_op = 3'b100; #1;
    n_tests++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++; $display("FAIL ar_first_tie: got r1r0=%b required 01", {req1_ready, req0_ready});
    end
    step();
    req0_valid = 0; req1_valid = 0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_req1();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
